// File: rtl/mem_bus_scheduler_pkg.sv
// Shared types and constants for the Sysbus memory-port scheduler.
// Package name: mem_bus_pkg (state enum, source enum, tag field positions).
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  typedef enum logic {
    SRC_DC = 1'b0,
    SRC_IC = 1'b1
  } src_t;

  // Sysbus tag layout: bit 12 write(1)/read(0), bits 11:8 type, bits 7:0 free.
  localparam int TAG_RW_BIT   = 12;
  localparam int TAG_TYPE_MSB = 11;
  localparam int TAG_TYPE_LSB = 8;

  // Default tag bit used to mark the owning cache (1 = I-cache).
  localparam int SRC_BIT_DEF  = 0;

  // Data beats per 64-byte line transfer.
  localparam int BEATS_DEF    = 8;

endpackage

// File: rtl/mem_bus_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter (I-cache vs D-cache). Grants only while
// grant_en is high; on a tie the requester that did not win last time wins.
// rr_last resets to SRC_DC so the I-cache wins the first tie.
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req_ic,
  input  logic req_dc,
  input  logic grant_en,
  output logic gnt_ic,
  output logic gnt_dc
);

  src_t last_q, last_d;

  // Grant selection and rr_last update
  always_comb begin
    gnt_ic = 1'b0;
    gnt_dc = 1'b0;
    last_d = last_q;
    if (grant_en) begin
      if (req_ic && req_dc) begin
        if (last_q == SRC_DC) gnt_ic = 1'b1;
        else                  gnt_dc = 1'b1;
      end else begin
        gnt_ic = req_ic;
        gnt_dc = req_dc;
      end
      if (gnt_ic)      last_d = SRC_IC;
      else if (gnt_dc) last_d = SRC_DC;
    end
  end

  // rr_last register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= SRC_DC;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/mem_bus_scheduler.sv
// Shares the Sysbus memory port between the L1 I-cache and D-cache.
// One line transaction at a time: IDLE -> ADDR -> (WDATA | RDATA) -> IDLE.
// Request handshake: *_req_valid is held by the cache until *_req_ready,
// which is a one-cycle pulse the cycle after the grant in IDLE. The bus
// request phase holds bus_reqcyc/bus_req/bus_reqtag until bus_reqack;
// response beats are consumed (bus_respack) in the same cycle bus_respcyc
// is seen. Optional macro MEM_BUS_SCHED_PERF_CNT_EN adds grant and wait
// counters.
module mem_bus_scheduler
  import mem_bus_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 13,
  parameter int SRC_BIT   = SRC_BIT_DEF,
  parameter int BEATS     = BEATS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ic_req_valid,
  input  logic [WIDTH-1:0]     ic_req_addr,
  input  logic [TAG_WIDTH-1:0] ic_req_tag,
  output logic                 ic_req_ready,
  output logic                 ic_resp_valid,
  output logic [WIDTH-1:0]     ic_resp_data,
  input  logic                 dc_req_valid,
  input  logic [WIDTH-1:0]     dc_req_addr,
  input  logic [TAG_WIDTH-1:0] dc_req_tag,
  input  logic [WIDTH-1:0]     dc_wdata,
  output logic [2:0]           dc_wbeat,
  output logic                 dc_req_ready,
  output logic                 dc_resp_valid,
  output logic [WIDTH-1:0]     dc_resp_data,
  output logic                 bus_reqcyc,
  output logic [WIDTH-1:0]     bus_req,
  output logic [TAG_WIDTH-1:0] bus_reqtag,
  input  logic                 bus_reqack,
  input  logic                 bus_respcyc,
  input  logic [WIDTH-1:0]     bus_resp,
  input  logic [TAG_WIDTH-1:0] bus_resptag,
  output logic                 bus_respack,
  output logic                 err_unexpected,
  output logic [1:0]           dbg_state
`ifdef MEM_BUS_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]          ic_grant_cnt,
  output logic [31:0]          dc_grant_cnt,
  output logic [31:0]          wait_cycles
`endif
);

  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 is_wr_q, is_wr_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 ic_rdy_q, ic_rdy_d;
  logic                 dc_rdy_q, dc_rdy_d;
  logic                 err_q, err_d;
  logic                 gnt_ic, gnt_dc;
  logic                 unused_resptag;

  // Only the source bit of the response tag matters for routing.
  assign unused_resptag = ^bus_resptag;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_ic   (ic_req_valid),
    .req_dc   (dc_req_valid),
    .grant_en (state_q == ST_IDLE),
    .gnt_ic   (gnt_ic),
    .gnt_dc   (gnt_dc)
  );

  // State register and transaction context
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      tag_q    <= '0;
      is_wr_q  <= 1'b0;
      cnt_q    <= '0;
      ic_rdy_q <= 1'b0;
      dc_rdy_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tag_q    <= tag_d;
      is_wr_q  <= is_wr_d;
      cnt_q    <= cnt_d;
      ic_rdy_q <= ic_rdy_d;
      dc_rdy_q <= dc_rdy_d;
      err_q    <= err_d;
    end
  end

  // Next-state: grant, address phase, write beats, read beats
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tag_d    = tag_q;
    is_wr_d  = is_wr_q;
    cnt_d    = cnt_q;
    ic_rdy_d = 1'b0;
    dc_rdy_d = 1'b0;
    // A response beat with no read in flight is dropped and flagged.
    err_d    = err_q | (bus_respcyc && (state_q != ST_RDATA));
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_ic) begin
          addr_d         = ic_req_addr;
          tag_d          = ic_req_tag;
          tag_d[SRC_BIT] = 1'b1;
          is_wr_d        = 1'b0;  // the I-cache never writes
          ic_rdy_d       = 1'b1;
          state_d        = ST_ADDR;
        end else if (gnt_dc) begin
          addr_d         = dc_req_addr;
          tag_d          = dc_req_tag;
          tag_d[SRC_BIT] = 1'b0;
          is_wr_d        = dc_req_tag[TAG_RW_BIT];
          dc_rdy_d       = 1'b1;
          state_d        = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus_reqack) begin
          cnt_d   = '0;
          state_d = is_wr_q ? ST_WDATA : ST_RDATA;
        end
      end
      ST_WDATA: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_BEAT) state_d = ST_IDLE;
      end
      ST_RDATA: begin
        if (bus_respcyc) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LAST_BEAT) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: bus request drive, write-beat index, response routing
  always_comb begin
    bus_reqcyc    = 1'b0;
    bus_req       = '0;
    bus_reqtag    = '0;
    dc_wbeat      = '0;
    ic_resp_valid = 1'b0;
    ic_resp_data  = '0;
    dc_resp_valid = 1'b0;
    dc_resp_data  = '0;
    // Every presented beat is consumed; outside RDATA it is simply dropped.
    bus_respack   = bus_respcyc & reset_n;
    unique case (state_q)
      ST_ADDR: begin
        bus_reqcyc = 1'b1;
        bus_req    = addr_q;
        bus_reqtag = tag_q;
      end
      ST_WDATA: begin
        bus_reqcyc = 1'b1;
        bus_req    = dc_wdata;
        bus_reqtag = tag_q;
        dc_wbeat   = cnt_q;
      end
      ST_RDATA: begin
        if (bus_respcyc) begin
          if (bus_resptag[SRC_BIT]) begin
            ic_resp_valid = 1'b1;
            ic_resp_data  = bus_resp;
          end else begin
            dc_resp_valid = 1'b1;
            dc_resp_data  = bus_resp;
          end
        end
      end
      default: ;
    endcase
  end

  assign ic_req_ready   = ic_rdy_q;
  assign dc_req_ready   = dc_rdy_q;
  assign err_unexpected = err_q;
  assign dbg_state      = state_q;

`ifdef MEM_BUS_SCHED_PERF_CNT_EN
  logic [31:0] ic_cnt_q, ic_cnt_d, dc_cnt_q, dc_cnt_d, wait_q, wait_d;
  logic        waiting;

  // A request is waiting when valid but neither granted nor being acknowledged.
  always_comb begin
    waiting  = (ic_req_valid && !gnt_ic && !ic_rdy_q) ||
               (dc_req_valid && !gnt_dc && !dc_rdy_q);
    ic_cnt_d = ic_cnt_q + {31'd0, gnt_ic};
    dc_cnt_d = dc_cnt_q + {31'd0, gnt_dc};
    wait_d   = wait_q + {31'd0, waiting};
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ic_cnt_q <= '0;
      dc_cnt_q <= '0;
      wait_q   <= '0;
    end else begin
      ic_cnt_q <= ic_cnt_d;
      dc_cnt_q <= dc_cnt_d;
      wait_q   <= wait_d;
    end
  end

  assign ic_grant_cnt = ic_cnt_q;
  assign dc_grant_cnt = dc_cnt_q;
  assign wait_cycles  = wait_q;
`endif

endmodule

// File: doc/mem_bus_scheduler.md
Name: mem_bus_scheduler

Overview:
- Shares the single Sysbus memory port between the L1 instruction cache and the L1 data cache.
- Grants one line transaction at a time, using round-robin priority between the two caches.
- Stamps the 13-bit request tag with a source bit and sequences the request, write-data and read-response phases.
- Routes returning beats to the owning cache by that tag bit; sits between the L1 caches and the top-level bus.

Parameters:
- WIDTH, 64, bus data/address width in bits
- TAG_WIDTH, 13, Sysbus tag width; bit 12 = write(1)/read(0), bits 11:8 = type, bits 7:0 = free
- SRC_BIT, 0, tag bit index marking the source: 1 = instruction cache, 0 = data cache
- BEATS, 8, data beats per line transfer (64-byte line)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- ic_req_valid  in  1  I-cache request pending; held until ic_req_ready
- ic_req_addr  in  WIDTH  I-cache line address
- ic_req_tag  in  TAG_WIDTH  I-cache tag; bit SRC_BIT ignored
- ic_req_ready  out  1  one-cycle pulse: I-cache request accepted
- ic_resp_valid  out  1  I-cache read beat valid
- ic_resp_data  out  WIDTH  I-cache read beat
- dc_req_valid  in  1  D-cache request pending
- dc_req_addr  in  WIDTH  D-cache line address
- dc_req_tag  in  TAG_WIDTH  D-cache tag; bit SRC_BIT ignored
- dc_wdata  in  WIDTH  D-cache write beat, indexed by dc_wbeat
- dc_wbeat  out  3  write beat index requested from the D-cache
- dc_req_ready  out  1  one-cycle pulse: D-cache request accepted
- dc_resp_valid  out  1  D-cache read beat valid
- dc_resp_data  out  WIDTH  D-cache read beat
- bus_reqcyc  out  1  Sysbus request cycle
- bus_req  out  WIDTH  address, then write beats
- bus_reqtag  out  TAG_WIDTH  stamped tag
- bus_reqack  in  1  Sysbus request accepted
- bus_respcyc  in  1  response beat present
- bus_resp  in  WIDTH  response beat
- bus_resptag  in  TAG_WIDTH  response tag
- bus_respack  out  1  response beat consumed
- err_unexpected  out  1  sticky: a response arrived with no read outstanding

Behaviour:
- Reset (async, reset_n=0): state IDLE, rr_last=DC so the I-cache wins the first tie, beat counter 0. All outputs 0, err_unexpected cleared.
- States: IDLE, ADDR, WDATA, RDATA.
- IDLE:
  - Pick a requester: if both are valid, choose the one not equal to rr_last; otherwise take the single valid one.
  - Latch address and tag, then force tag[SRC_BIT] = (source==IC).
  - Pulse the winner's *_req_ready for one cycle, update rr_last, go to ADDR. Latency: valid to ready = 1 cycle from IDLE.
- ADDR:
  - Drive bus_reqcyc=1 with bus_req=address and bus_reqtag=stamped tag; hold these stable until bus_reqack.
  - On ack: if tag[12]=1 go to WDATA with beat counter 0; otherwise go to RDATA.
- WDATA:
  - Each cycle: bus_reqcyc=1, bus_req=dc_wdata, dc_wbeat=counter, counter+1.
  - No backpressure. After beat BEATS-1, go to IDLE.
  - Writes are data-cache only; an I-cache request with tag[12]=1 is treated as a read.
- RDATA:
  - While bus_respcyc=1, drive bus_respack=1 combinationally.
  - Forward bus_resp to ic_resp_* when bus_resptag[SRC_BIT]=1, else to dc_resp_*; the valid is asserted the same cycle, no register stage.
  - Counter +1 per beat; after beat BEATS-1, go to IDLE.
  - Gaps in bus_respcyc are allowed; the counter holds.
- bus_respcyc outside RDATA: ack it, drop the beat, set err_unexpected.
- The beat counter is 3 bits and wraps naturally at BEATS=8.
- Requests arriving during a transaction wait; a requester's valid must stay high until its ready.
- A requester is never granted twice in a row while the other is waiting.

Optional Feature:
- Macro: MEM_BUS_SCHED_PERF_CNT_EN.
- Defined: adds 32-bit outputs ic_grant_cnt and dc_grant_cnt plus wait_cycles. The grant counters increment on each grant; wait_cycles increments every cycle a valid request sits unserved. All reset to 0 and wrap at 2^32.
- Undefined: none of these ports or registers exist.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state enum
  - source enum {SRC_DC, SRC_IC}
  - tag field constants: TAG_RW_BIT=12, TAG_TYPE_MSB=11, TAG_TYPE_LSB=8, SRC_BIT default
  - BEATS
- One sub-module, rr_arbiter2: two-input round-robin grant with an rr_last register and grant-enable. The FSM stays in mem_bus_scheduler.

Test Plan:
- IC read only, addr 0x1000, tag 0x0100:
  - ic_req_ready pulses; bus_reqtag = 0x0101; reqack after 3 cycles.
  - 8 beats 0xA0..0xA7 appear on ic_resp_data; dc_resp_valid stays 0.
- DC write, tag 0x1100:
  - bus_reqtag = 0x1100; after ack, dc_wbeat runs 0..7 on consecutive cycles.
  - bus_req carries dc_wdata; return to IDLE after beat 7.
- IC and DC valid in the same cycle from reset, both held:
  - Grant order IC, DC, IC, DC over 4 transactions.
- Read response with 2-cycle gaps between beats:
  - Exactly 8 beats are routed; the counter holds during gaps; no early exit.
- bus_respcyc=1 while IDLE:
  - bus_respack=1, no *_resp_valid, err_unexpected=1 until reset.
- reset_n low mid-RDATA after beat 3:
  - All outputs 0 immediately; state IDLE.
  - After release, an IC request is granted first.
